nand_stim_gen: RTL and testbench

- Synthesizable upstream stimulus stage for the nand_four gate block. It drives its a, b, c, d inputs with four independent square waves, each with a programmable half-period.
- Runs for a fixed number of clock cycles, then halts. Start, pause and stop controls let a board-level or bench controller sequence the run.
- Replaces free-running delay-based stimulus with clocked, countable behaviour.

---
 rtl/nand_stim_gen.sv | 196 +++++++++++++++++++
 tb/tb_nand_stim_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_stim_gen.sv
// nand_stim_gen: clocked stimulus source for the nand_four gate block.
// Four independent square waves (a, b, c, d), each with its own half-period.
// A run lasts RUN_LEN advancing cycles. start, pause and stop sequence the run.
// Optional macro NAND_STIM_STEP_EN adds a 'step' input.
// While paused, step advances the run by one cycle per clk while it is high.
`timescale 1ns/1ps

// One square-wave channel.
// Its output toggles after every HP advancing cycles.
module nand_stim_chan #(
  parameter int CNT_W = 8,
  parameter int HP    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic wave
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HP - 1);

  logic [CNT_W-1:0] hp_cnt;

  // Half-period countdown.
  // Reaching zero flips the wave and restarts the countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt <= RELOAD;
      wave   <= 1'b0;
    end else if (clear) begin
      hp_cnt <= RELOAD;
      wave   <= 1'b0;
    end else if (advance) begin
      if (hp_cnt == '0) begin
        hp_cnt <= RELOAD;
        wave   <= ~wave;
      end else begin
        hp_cnt <= hp_cnt - CNT_W'(1);
      end
    end
  end

endmodule

module nand_stim_gen #(
  parameter int CNT_W   = 8,
  parameter int HP_A    = 2,
  parameter int HP_B    = 3,
  parameter int HP_C    = 4,
  parameter int HP_D    = 5,
  parameter int RUN_LEN = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
`ifdef NAND_STIM_STEP_EN
  input  logic             step,
`endif
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // cycle_cnt value during the final advancing cycle of a run.
  // With RUN_LEN == 2^CNT_W the count then wraps to zero on purpose.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_LEN - 1);

  state_t state;
  state_t state_nxt;
  logic   clear_all;
  logic   advance;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, plus the clear and advance strobes for the datapath.
  // stop outranks everything else.
  // Leaving PAUSE back to RUN does not advance on that same edge.
  always_comb begin
    state_nxt = state;
    clear_all = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_RUN;
          clear_all = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          clear_all = 1'b1;
        end else if (pause) begin
          state_nxt = ST_PAUSE;
        end else begin
          advance = 1'b1;
          if (cycle_cnt == LAST_CNT) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          clear_all = 1'b1;
        end else if (!pause) begin
          state_nxt = ST_RUN;
`ifdef NAND_STIM_STEP_EN
        end else if (step) begin
          advance = 1'b1;
          if (cycle_cnt == LAST_CNT) begin
            state_nxt = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          clear_all = 1'b1;
        end else if (start) begin
          state_nxt = ST_RUN;
          clear_all = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        clear_all = 1'b1;
      end
    endcase
  end

  // Count of advancing cycles in the current run.
  // After the last cycle it holds RUN_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (clear_all) begin
      cycle_cnt <= '0;
    end else if (advance) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Status flags are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
      paused <= (state_nxt == ST_PAUSE);
      done   <= (state_nxt == ST_DONE);
    end
  end

  nand_stim_chan #(.CNT_W(CNT_W), .HP(HP_A)) u_chan_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .advance(advance), .wave(a)
  );

  nand_stim_chan #(.CNT_W(CNT_W), .HP(HP_B)) u_chan_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .advance(advance), .wave(b)
  );

  nand_stim_chan #(.CNT_W(CNT_W), .HP(HP_C)) u_chan_c (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .advance(advance), .wave(c)
  );

  nand_stim_chan #(.CNT_W(CNT_W), .HP(HP_D)) u_chan_d (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .advance(advance), .wave(d)
  );

endmodule

// File: tb/tb_nand_stim_gen.sv
// Testbench for nand_stim_gen.
// A cycle-level reference model pushes the expected outputs onto a queue.
// After each clock edge the oldest entry is popped and compared with the DUT.
// Each channel's expected wave is (advances / HP) mod 2.
`timescale 1ns/1ps

module tb_nand_stim_gen;

  localparam int CNT_W   = 8;
  localparam int HP_A    = 2;
  localparam int HP_B    = 3;
  localparam int HP_C    = 4;
  localparam int HP_D    = 5;
  localparam int RUN_LEN = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int wave;
    int status;
    int cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             pause;
  logic             stop;
  logic             step;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             paused;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  int   total;
  int   bad;
  int   m_state;
  int   m_adv;
  exp_t exp_q[$];

  int a_tab[12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  int b_tab[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

  nand_stim_gen #(
    .CNT_W(CNT_W), .HP_A(HP_A), .HP_B(HP_B), .HP_C(HP_C), .HP_D(HP_D),
    .RUN_LEN(RUN_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .stop(stop),
`ifdef NAND_STIM_STEP_EN
    .step(step),
`endif
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .busy(busy),
    .paused(paused),
    .done(done),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic t);
    start = s;
    pause = p;
    stop  = t;
  endtask

  // Advance the reference model by one clock, using the inputs the DUT will sample.
  task automatic model_step();
    logic step_on;
    step_on = 1'b0;
`ifdef NAND_STIM_STEP_EN
    step_on = step;
`endif
    case (m_state)
      M_IDLE: begin
        if (start && !stop) begin
          m_state = M_RUN;
          m_adv = 0;
        end
      end
      M_RUN: begin
        if (stop) begin
          m_state = M_IDLE;
          m_adv = 0;
        end else if (pause) begin
          m_state = M_PAUSE;
        end else begin
          m_adv++;
          if (m_adv == RUN_LEN) m_state = M_DONE;
        end
      end
      M_PAUSE: begin
        if (stop) begin
          m_state = M_IDLE;
          m_adv = 0;
        end else if (!pause) begin
          m_state = M_RUN;
        end else if (step_on) begin
          m_adv++;
          if (m_adv == RUN_LEN) m_state = M_DONE;
        end
      end
      default: begin
        if (stop) begin
          m_state = M_IDLE;
          m_adv = 0;
        end else if (start) begin
          m_state = M_RUN;
          m_adv = 0;
        end
      end
    endcase
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    if (m_state == M_IDLE) begin
      e.wave = 0;
    end else begin
      e.wave = (((m_adv / HP_A) % 2) << 3) | (((m_adv / HP_B) % 2) << 2) |
               (((m_adv / HP_C) % 2) << 1) | ((m_adv / HP_D) % 2);
    end
    e.status = (((m_state == M_RUN) || (m_state == M_PAUSE)) ? 4 : 0) |
               ((m_state == M_PAUSE) ? 2 : 0) | ((m_state == M_DONE) ? 1 : 0);
    e.cnt = m_adv % (1 << CNT_W);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    model_step();
    exp_q.push_back(model_expect());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("wave_abcd", int'({a, b, c, d}), e.wave);
    checkOutput("status_bpd", int'({busy, paused, done}), e.status);
    checkOutput("cycle_cnt", int'(cycle_cnt), e.cnt);
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_wave"}, int'({a, b, c, d}), 0);
    checkOutput({tag, "_status"}, int'({busy, paused, done}), 0);
    checkOutput({tag, "_cnt"}, int'(cycle_cnt), 0);
  endtask

  task automatic start_run();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input int target);
    for (int n = 0; n < 400; n++) begin
      if (m_state == M_RUN && m_adv == target) break;
      tick();
    end
    checkOutput("reach_cnt", int'(cycle_cnt), target);
  endtask

  task automatic run_to_done();
    for (int n = 0; n < 400; n++) begin
      if (m_state == M_DONE) break;
      tick();
    end
    checkOutput("reach_done", int'(done), 1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_state = M_IDLE;
    m_adv = 0;
    rst_n = 1'b0;
    step = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] idle: pause and stop are ignored");
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();

    $display("[TB] basic waveform run");
    start_run();
    for (int k = 0; k < 12; k++) begin
      checkOutput("a_table", int'(a), a_tab[k]);
      checkOutput("b_table", int'(b), b_tab[k]);
      tick();
    end
    run_to_done();
    checkOutput("done_cnt", int'(cycle_cnt), RUN_LEN % (1 << CNT_W));
    for (int k = 0; k < 3; k++) tick();

    $display("[TB] restart from done with a 7-cycle pause");
    start_run();
    run_until(10);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    checkOutput("pause_cnt", int'(cycle_cnt), 10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    run_to_done();

    $display("[TB] stop beats start");
    start_run();
    run_until(37);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("[TB] stop from pause and from done");
    start_run();
    run_until(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    start_run();
    run_to_done();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    start_run();
    run_until(3);
    checkOutput("a_before_reset", int'(a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    m_state = M_IDLE;
    m_adv = 0;
    @(posedge clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    tick();

`ifdef NAND_STIM_STEP_EN
    $display("[TB] single-step while paused");
    start_run();
    run_until(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    checkOutput("step_cnt", int'(cycle_cnt), 8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    run_until(99);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("step_done", int'(done), 1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
